// File: rtl/sloth_pid_pkg.sv
`default_nettype none
// sloth_pid_pkg: shared word type, 16-bit limits and the clip helper used by the sloth_pid blocks.
package sloth_pid_pkg;

  typedef logic signed [15:0] word_t;

  localparam word_t WORD_MAX = 16'sh7FFF;
  localparam word_t WORD_MIN = 16'sh8000;

  localparam int SAT_IN_W = 64;
  localparam logic signed [SAT_IN_W-1:0] SAT_HI = 64'sd32767;
  localparam logic signed [SAT_IN_W-1:0] SAT_LO = -64'sd32768;

  typedef struct packed {
    word_t val;
    logic  sat;
  } sat16_t;

  // Callers sign-extend their wide value to SAT_IN_W bits before clipping.
  function automatic sat16_t sat16(input logic signed [SAT_IN_W-1:0] v);
    sat16_t r;
    r.sat = 1'b1;
    r.val = WORD_MAX;
    if (v > SAT_HI) begin
      r.val = WORD_MAX;
    end else if (v < SAT_LO) begin
      r.val = WORD_MIN;
    end else begin
      r.val = v[15:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sloth_pid_satadd.sv
`default_nettype none
// sloth_pid_satadd: W-bit signed adder that clamps to the W-bit signed range instead of wrapping.
module sloth_pid_satadd #(
  parameter int W = 24
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_y
);

  logic signed [W:0] w_sum;

  assign w_sum = {i_a[W-1], i_a} + {i_b[W-1], i_b};

  // Overflow shows up as the two top bits of the widened sum disagreeing.
  always_comb begin
    o_y = w_sum[W-1:0];
    if (w_sum[W] != w_sum[W-1]) begin
      o_y = w_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule
`default_nettype wire

// File: rtl/sloth_pid_accum.sv
`default_nettype none
// sloth_pid_accum: 2-stage PID combiner with saturating integrator and delivered-sample counter.
// Optional conditional anti-windup when SLOTH_PID_ANTIWINDUP_EN is defined.
module sloth_pid_accum
  import sloth_pid_pkg::*;
#(
  parameter int ACC_W   = 24,
  parameter int I_SHIFT = 4,
  parameter int D_SHIFT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  word_t       in_y3,
  input  word_t       in_y2,
  input  word_t       in_y1,
  input  word_t       in_y0,
  output logic        out_valid,
  input  logic        out_ready,
  output word_t       out_data,
  output logic        out_sat,
  output logic [15:0] out_count
);

  localparam int SUM_W = ACC_W + 2;

  logic signed [ACC_W-1:0] r_acc;
  word_t                   r_p;
  logic signed [16:0]      r_d;
  logic                    r_s1_valid;
  logic                    r_s2_valid;
  word_t                   r_out_data;
  logic                    r_out_sat;
  logic [15:0]             r_count;

  logic                    w_en;
  logic                    w_accept;
  logic                    w_acc_upd;
  logic signed [ACC_W-1:0] w_y1_ext;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [16:0]      w_d_new;
  logic signed [ACC_W-1:0] w_acc_sh;
  logic signed [16:0]      w_d_sh;
  logic signed [SUM_W-1:0] w_sum;
  sat16_t                  w_clip;

  assign w_en     = !r_s2_valid || out_ready;
  assign in_ready = w_en && !clr;
  assign w_accept = in_valid && in_ready;

  assign w_y1_ext = {{(ACC_W-16){in_y1[15]}}, in_y1};
  assign w_d_new  = {in_y2[15], in_y2} - {in_y3[15], in_y3};

  sloth_pid_satadd #(
    .W (ACC_W)
  ) u_int_add (
    .i_a (r_acc),
    .i_b (w_y1_ext),
    .o_y (w_acc_next)
  );

`ifdef SLOTH_PID_ANTIWINDUP_EN
  logic r_sat_last;
  logic w_skip;

  // Freeze only when the increment pushes further into the clip the last output hit.
  assign w_skip    = r_sat_last && (r_out_data[15] ? in_y1[15] : (!in_y1[15] && (in_y1 != '0)));
  assign w_acc_upd = w_accept && !w_skip;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_sat_last <= 1'b0;
    end else if (w_en && r_s1_valid) begin
      r_sat_last <= w_clip.sat;
    end
  end
`else
  assign w_acc_upd = w_accept;
`endif

  // No accept can follow the stage-1 sample without moving it on, so r_acc is its post-update value.
  assign w_acc_sh = r_acc >>> I_SHIFT;
  assign w_d_sh   = r_d >>> D_SHIFT;
  assign w_sum    = {{(SUM_W-16){r_p[15]}}, r_p}
                  + {{2{w_acc_sh[ACC_W-1]}}, w_acc_sh}
                  + {{(SUM_W-17){w_d_sh[16]}}, w_d_sh};
  assign w_clip   = sat16({{(SAT_IN_W-SUM_W){w_sum[SUM_W-1]}}, w_sum});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_p        <= '0;
      r_d        <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
      r_count    <= '0;
    end else if (clr) begin
      r_acc      <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_acc_upd) begin
        r_acc <= w_acc_next;
      end
      if (w_en) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_p <= in_y0;
          r_d <= w_d_new;
        end
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_clip.val;
          r_out_sat  <= w_clip.sat;
        end
      end
      if (r_s2_valid && out_ready) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sloth_pid_accum.sv
`default_nettype none
// tb_sloth_pid_accum: directed scenarios plus a random stream scored against a transaction-level model.
module tb_sloth_pid_accum;

  localparam int     ACC_W   = 24;
  localparam longint ACC_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W-1));
`ifdef SLOTH_PID_ANTIWINDUP_EN
  localparam bit AW_EN = 1'b1;
`else
  localparam bit AW_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic signed [15:0] in_y3, in_y2, in_y1, in_y0, out_data;
  logic [15:0]        out_count;

  always #5 clk = ~clk;

  sloth_pid_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y3     (in_y3),
    .in_y2     (in_y2),
    .in_y1     (in_y1),
    .in_y0     (in_y0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  typedef struct {
    longint d;
    bit     s;
  } exp_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  exp_t   q[$];
  longint m_acc = 0;
  int     m_count = 0;
  bit     m_sat_last = 0;
  bit     m_sat_pos = 0;
  bit     prev_hold = 0;
  longint prev_data = 0;
  bit     mon_valid, mon_sat, got, got_sat, acc_flag, seen_stall;
  longint mon_data, got_data;

  task automatic chk(string tag, longint obs, longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint clip(longint v, longint lo, longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference: integrate, then combine the three terms and clip, all in plain wide arithmetic.
  task automatic model_accept(logic signed [15:0] y3, logic signed [15:0] y2,
                              logic signed [15:0] y1, logic signed [15:0] y0);
    longint d, s;
    bit skip;
    exp_t e;
    skip = AW_EN && m_sat_last && ((m_sat_pos && y1 > 0) || (!m_sat_pos && y1 < 0));
    if (!skip) m_acc = clip(m_acc + longint'(y1), ACC_MIN, ACC_MAX);
    d = longint'(y2) - longint'(y3);
    s = longint'(y0) + (m_acc >>> 4) + (d >>> 1);
    e.d = clip(s, -32768, 32767);
    e.s = (s > 32767) || (s < -32768);
    q.push_back(e);
  endtask

  // One clock: observe at negedge, drive, then predict what the next rising edge does.
  task automatic cyc(bit v, bit ordy, bit cl, bit rn, logic signed [15:0] y3,
                     logic signed [15:0] y2, logic signed [15:0] y1, logic signed [15:0] y0);
    @(negedge clk);
    mon_valid = out_valid;
    mon_data  = longint'(out_data);
    mon_sat   = out_sat;
    chk("count", longint'(out_count), m_count);
    chk("acc", longint'(dut.r_acc), m_acc);
    if (out_valid) begin
      chk("sb_nonempty", longint'(q.size() != 0), 1);
      if (q.size() != 0) begin
        chk("data", mon_data, q[0].d);
        chk("sat", longint'(mon_sat), longint'(q[0].s));
        if (!prev_hold) begin
          m_sat_last = q[0].s;
          m_sat_pos  = q[0].d >= 0;
        end
      end
      if (prev_hold) chk("hold", mon_data, prev_data);
    end
    in_valid = v; out_ready = ordy; clr = cl; rst_n = rn;
    in_y3 = y3; in_y2 = y2; in_y1 = y1; in_y0 = y0;
    #1;
    acc_flag = 0;
    got = 0;
    if (!rn) begin
      q.delete(); m_acc = 0; m_count = 0; m_sat_last = 0; prev_hold = 0;
    end else begin
      chk("in_ready", longint'(in_ready), longint'(!cl && (!out_valid || ordy)));
      if (cl) begin
        q.delete(); m_acc = 0; m_sat_last = 0; prev_hold = 0;
      end else begin
        if (out_valid && ordy) begin
          got = 1; got_data = mon_data; got_sat = mon_sat;
          if (q.size() != 0) void'(q.pop_front());
          m_count = (m_count + 1) % 65536;
        end
        prev_hold = out_valid && !ordy;
        prev_data = mon_data;
        if (v && !in_ready) seen_stall = 1;
        if (v && in_ready) begin
          acc_flag = 1;
          model_accept(y3, y2, y1, y0);
        end
      end
    end
  endtask

  task automatic idle();
    cyc(0, 1, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic send(logic signed [15:0] y3, logic signed [15:0] y2,
                      logic signed [15:0] y1, logic signed [15:0] y0);
    int n = 0;
    do begin
      cyc(1, 1, 0, 1, y3, y2, y1, y0);
      n++;
    end while (!acc_flag && n < 50);
    chk("send_timeout", longint'(acc_flag), 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      idle();
      n++;
    end
    chk("drain", longint'(q.size()), 0);
  endtask

  function automatic logic signed [15:0] rnd_word();
    case ($urandom_range(0, 4))
      0:       return 16'sh7FFF;
      1:       return 16'sh8000;
      2:       return 16'($signed($urandom_range(0, 64)) - 32);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int     lat, k;
    longint cnt, a0;
    longint outs[$];
    bit     pend;
    logic signed [15:0] ry3, ry2, ry1, ry0;

    rst_n = 0; clr = 0; in_valid = 0; out_ready = 0;
    in_y3 = 0; in_y2 = 0; in_y1 = 0; in_y0 = 0;
    repeat (2) @(posedge clk);

    // Reset state
    idle();
    chk("rst_valid", longint'(mon_valid), 0);
    chk("rst_data", mon_data, 0);
    chk("rst_sat", longint'(mon_sat), 0);

    // Single sample latency and value
    cyc(1, 1, 0, 1, 4, 10, 16, 100);
    chk("t1_accept", longint'(acc_flag), 1);
    lat = 0;
    do begin
      idle();
      lat++;
    end while (!mon_valid && lat < 10);
    chk("t1_latency", lat, 2);
    chk("t1_data", mon_data, 104);
    chk("t1_sat", longint'(mon_sat), 0);
    idle();
    chk("t1_count", longint'(out_count), 1);

    // Back-to-back stream with a 3-cycle downstream stall
    do_reset();
    seen_stall = 0; k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      cyc(1, !(c >= 2 && c < 5), 0, 1, 0, 0, 16, 0);
      if (got) outs.push_back(got_data);
      if (acc_flag) k++;
    end
    for (int c = 0; c < 20 && outs.size() < 4; c++) begin
      idle();
      if (got) outs.push_back(got_data);
    end
    idle();
    chk("t2_n", longint'(outs.size()), 4);
    for (int i = 0; i < 4; i++) chk("t2_seq", (outs.size() > i) ? outs[i] : -1, i + 1);
    chk("t2_stall", longint'(seen_stall), 1);
    chk("t2_count", longint'(out_count), 4);

    // Integrator saturation
    do_reset();
    repeat (300) send(0, 0, 16'sh7FFF, 0);
    drain();
    chk("t3_acc", longint'(dut.r_acc), 8388607);
    chk("t3_data", got_data, 32767);
    chk("t3_sat", longint'(got_sat), 1);

    // Negative output clip
    do_reset();
    send(16'sh7FFF, 16'sh8000, 0, 16'sh8000);
    drain();
    chk("t4_data", got_data, -32768);
    chk("t4_sat", longint'(got_sat), 1);

    // clr with both stages full and input pending
    cyc(1, 0, 0, 1, 0, 0, 16, 0);
    cyc(1, 0, 0, 1, 0, 0, 16, 0);
    cnt = longint'(out_count);
    cyc(1, 1, 1, 1, 0, 0, 16, 0);
    chk("t5_full", longint'(mon_valid), 1);
    chk("t5_noaccept", longint'(acc_flag), 0);
    idle();
    chk("t5_valid", longint'(mon_valid), 0);
    chk("t5_acc", longint'(dut.r_acc), 0);
    chk("t5_count", longint'(out_count), cnt);
    send(0, 0, 16, 0);
    drain();
    chk("t5_data", got_data, 1);

    // Anti-windup after positive saturation
    do_reset();
    repeat (40) send(0, 0, 16'sh7FFF, 0);
    drain();
    chk("t6_sat", longint'(got_sat), 1);
    a0 = longint'(dut.r_acc);
    send(0, 0, 100, 0);
    drain();
    chk("t6_pos", longint'(dut.r_acc) - a0, AW_EN ? 0 : 100);
    a0 = longint'(dut.r_acc);
    send(0, 0, -100, 0);
    drain();
    chk("t6_neg", longint'(dut.r_acc) - a0, -100);

    // Random stream with random backpressure and occasional clr
    do_reset();
    pend = 0;
    ry3 = 0; ry2 = 0; ry1 = 0; ry0 = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend) begin
        ry3 = rnd_word(); ry2 = rnd_word(); ry1 = rnd_word(); ry0 = rnd_word();
        pend = $urandom_range(0, 3) != 0;
      end
      cyc(pend, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, 1, ry3, ry2, ry1, ry0);
      if (acc_flag) pend = 0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
